rate_counter_ud: RTL
====================

# rate_counter_ud

Parametrised up/down counter with a built-in programmable rate prescaler, replacing the divided-clock-plus-mux arrangement used on the LED counter boards. Everything runs on the single system clock: the prescaler produces a one-cycle count-enable strobe at a selectable rate, and the counter advances on that strobe. The block adds a programmable modulo limit, wrap or saturate mode, synchronous load and a terminal-count pulse. Its `count` output drives the LED bank directly.

## Interface

Parameters:
- `WIDTH`, default 8: counter width in bits.
- `SEL_W`, default 2: width of rate select; `2**SEL_W` rates.
- `TAP_BASE`, default 20: log2 of the tick period for `sel` = 0.
- `TAP_STEP`, default 2: log2 increment of the period per `sel` step.
- Derived `PRE_W` = `TAP_BASE + TAP_STEP*(2**SEL_W - 1)`: prescaler width, minimum 1.

Ports:
- `clk`  in  1: system clock, all logic on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `sel`  in  SEL_W: rate select, so the tick period for `sel` = k is `2**(TAP_BASE + k*TAP_STEP)` clocks.
- `en`  in  1: count enable; the prescaler keeps running when `en` is low.
- `UD`  in  1: direction, 1 = up, 0 = down.
- `sat`  in  1: 1 = saturate at the boundary, 0 = wrap.
- `limit`  in  WIDTH: inclusive upper bound, so the count range is 0..`limit`.
- `load`  in  1: synchronous load request.
- `load_val`  in  WIDTH: value to load.
- `count`  out  WIDTH: registered counter value, driven to the LEDs.
- `tc`  out  1: registered one-cycle terminal-count pulse.
- `tick`  out  1: combinational rate strobe for the currently selected rate.

## Operation

**Prescaler**
- `pre`, PRE_W bits, increments every cycle and wraps freely at `2**PRE_W`.
- `tick` = 1 when the low `n` bits of `pre` are all ones, where `n = TAP_BASE + sel*TAP_STEP`.
- `n` = 0 means `tick` is constantly 1.

**Priority per clock edge**
1. `reset`
2. `load`
3. `en && tick` step
4. hold

**Reset**
- `count` = 0, `pre` = 0, `tc` = 0.

**Load**
- `count` <= `load_val`, `tc` <= 0.
- A load takes precedence over a coincident tick; that step is lost.

**Step up (`UD` = 1)**
- If `count >= limit`:
  - `sat` = 0: `count` <= 0, `tc` <= 1.
  - `sat` = 1: `count` <= `limit`, `tc` <= 1.
- Otherwise `count` <= `count` + 1, `tc` <= 0.

**Step down (`UD` = 0)**
- If `count` == 0:
  - `sat` = 0: `count` <= `limit`, `tc` <= 1.
  - `sat` = 1: `count` stays 0, `tc` <= 1.
- Otherwise:
  - If `count > limit`, `count` <= `limit` (pulls an out-of-range value back into range), `tc` <= 0.
  - Else `count` <= `count` - 1, `tc` <= 0.

**Other cycles**
- `tc` <= 0.

**Out-of-range values**
- A `load_val` above `limit` is loaded as-is.
- The next up step treats it as the boundary (wrap to 0 or clamp to `limit`).

**Limit = 0**
- The counter stays at 0.
- Every step pulses `tc`.

**Arithmetic**
- All comparisons are unsigned at WIDTH bits.
- Internal increment and decrement never overflow silently, because the boundary checks precede them.

## Timing

- `count` and `tc` update on the edge following the cycle where `tick && en` (or `load`) is sampled high; latency is 1 clock.
- `tc` is high for exactly one clock per boundary step.
- In saturate mode, `tc` repeats on every further tick while the count is held at the boundary.
- `tick` is combinational from `pre` and `sel`:
  - A `sel` change takes effect in the same cycle.
  - The prescaler is not reset on a `sel` change, so the first period after a change may be shorter.
- `UD`, `sat` and `limit` changes take effect on the next step; no other state is affected.
- `reset` asserted mid-count clears everything on that edge; the first tick after release occurs `2**n` clocks later, with `pre` counting from 0.

## Test plan

Use `TAP_BASE` = 1 and `TAP_STEP` = 1, so `sel` = 0/1/2/3 gives tick periods of 2/4/8/16 clocks.

- **Reset, then up count:** hold `reset` 3 clocks, then `sel` = 0, `en` = 1, `UD` = 1, `limit` = 255 -> `count` is 0 during reset, reaches 1 within 2 clocks of release, and increments every 2 clocks.
- **Wrap up:** `load_val` = 5, `limit` = 5, load, then up with `sat` = 0 -> next tick gives `count` = 0 with `tc` = 1 for one clock; the following tick gives 1 with `tc` = 0.
- **Saturate down:** load 1, `UD` = 0, `sat` = 1 -> ticks give 0, 0, 0; `tc` is 0 on the first tick, then 1 on the second and third.
- **Rate change:** `sel` = 3 -> steps every 16 clocks; switch to `sel` = 1 mid-period -> the next step comes within ≤4 clocks, then every 4 clocks.
- **Load/tick collision and out-of-range load:** assert `load` (`load_val` = 200) on a tick cycle with `limit` = 100, up mode -> `count` = 200 with no step; the next tick gives 0 with `tc` = 1 when `sat` = 0, or 100 with `tc` = 1 when `sat` = 1.
- **Reset mid-count and `en` low:** `en` = 0 for 20 clocks -> `count` is frozen while `tick` keeps pulsing; `reset` at `count` = 37 -> `count` and `tc` are 0 on the next edge.

Source files
------------

// File: rtl/rate_counter_ud.sv
// Up/down LED counter with an on-clock programmable rate prescaler, modulo limit,
// wrap/saturate boundary handling, synchronous load and a terminal-count pulse.
module rate_counter_ud #(
  parameter int WIDTH    = 8,
  parameter int SEL_W    = 2,
  parameter int TAP_BASE = 20,
  parameter int TAP_STEP = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  input  logic             UD,
  input  logic             sat,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             tick
);

  localparam int PRE_RAW = TAP_BASE + TAP_STEP * ((2 ** SEL_W) - 1);
  localparam int PRE_W   = (PRE_RAW < 1) ? 1 : PRE_RAW;

  logic [PRE_W-1:0] r_pre;
  logic [WIDTH-1:0] r_count;
  logic             r_tc;

  int               w_n;
  logic [PRE_W-1:0] w_mask;
  logic             w_tick;
  logic [WIDTH-1:0] w_step_count;
  logic             w_step_tc;

  // Up step: anything at or above the limit (including an out-of-range load) is the boundary.
  function automatic logic [WIDTH-1:0] f_step_up(input logic [WIDTH-1:0] cnt,
                                                 input logic [WIDTH-1:0] lim,
                                                 input logic             st);
    if (cnt >= lim) f_step_up = st ? lim : '0;
    else            f_step_up = cnt + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] f_step_down(input logic [WIDTH-1:0] cnt,
                                                   input logic [WIDTH-1:0] lim,
                                                   input logic             st);
    if (cnt == '0)      f_step_down = st ? '0 : lim;
    else if (cnt > lim) f_step_down = lim;
    else                f_step_down = cnt - WIDTH'(1);
  endfunction

  // Tick fires when the low n prescaler bits are all ones; n = 0 gives an all-zero mask.
  assign w_n = TAP_BASE + int'(sel) * TAP_STEP;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < PRE_W; i++) begin
      w_mask[i] = (i < w_n);
    end
  end

  assign w_tick = ((r_pre & w_mask) == w_mask);

  always_comb begin
    w_step_count = r_count;
    w_step_tc    = 1'b0;
    if (UD) begin
      w_step_count = f_step_up(r_count, limit, sat);
      w_step_tc    = (r_count >= limit);
    end else begin
      w_step_count = f_step_down(r_count, limit, sat);
      w_step_tc    = (r_count == '0);
    end
  end

  // Stage boundary: prescaler, count and terminal-count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre   <= '0;
      r_count <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
      if (load) begin
        r_count <= load_val;
        r_tc    <= 1'b0;
      end else if (en && w_tick) begin
        r_count <= w_step_count;
        r_tc    <= w_step_tc;
      end else begin
        r_tc    <= 1'b0;
      end
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign tick  = w_tick;

endmodule
